mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM stage of the 16-bit pipelined MIPS core. Consumes the EX/MEM pipeline register outputs and performs the load/store against an internal word-organised data memory. It resolves the branch decision and registers the MEM/WB pipeline values for the write-back stage. It can insert memory wait states, in which case it stalls the upstream pipeline until the access completes.

## Interface
- `DEPTH`, 256: data memory size in 16-bit words; must be a power of two.
- `AW`, 8: word-address width, log2(`DEPTH`).
- `WAIT_CYCLES`, 2: extra cycles per load/store when `MEM_WAIT_EN` is defined; valid range 1–15.
- `clk`, in, 1: clock. All state updates on the falling edge, matching the pipeline registers.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_MemRead`, `in_MemWrite`, in, 1 each: memory control signals from EX/MEM.
- `in_Branch`, `in_Zero`, in, 1 each: branch flag and ALU zero flag.
- `in_BranchTarget`, in, 16: PC+2+imm.
- `in_MemtoReg`, `in_RegWrite`, in, 1 each: write-back control signals.
- `in_ALUResult`, in, 16: memory byte address, or the ALU result to pass through.
- `in_Write_Data`, in, 16: store data.
- `in_WriteRegister`, in, 3: destination register.
- `O_PCSrc`, out, 1: combinational, `in_Branch & in_Zero`.
- `O_BranchTarget`, out, 16: combinational pass-through of `in_BranchTarget`.
- `O_Stall`, out, 1: combinational. When high, upstream stages must hold; EX/MEM must not update.
- `O_RegWrite`, `O_MemtoReg`, out, 1 each: MEM/WB registered control signals.
- `O_ReadData`, out, 16: MEM/WB registered load data.
- `O_ALUResult`, out, 16: MEM/WB registered ALU result.
- `O_WriteRegister`, out, 3: MEM/WB registered destination register.

## Operation
- **Word address:** `in_ALUResult[AW:1]`.
  - Bit 0 is ignored; there are no byte accesses.
  - Bits above `AW` are ignored, so addresses alias and wrap modulo `DEPTH`.
- **Access:** an access is `in_MemRead | in_MemWrite`.
  - If both are set, the access is treated as a store only, and `O_ReadData` is registered as 0.
- **FSM states:** IDLE and WAIT, plus a 4-bit down-counter `cnt`.
- **IDLE, no access:** on each edge, MEM/WB latches the inputs.
  - `O_ReadData` is latched as 0.
  - `O_Stall` = 0.
- **IDLE, access, wait states enabled:**
  - `O_Stall` = 1 combinationally.
  - On the edge: go to WAIT, load `cnt` = `WAIT_CYCLES`-1.
  - MEM/WB latches a bubble: `O_RegWrite` = 0, `O_MemtoReg` = 0, `O_WriteRegister` = 0. Data outputs hold their values.
  - Memory is not written.
- **WAIT:** `O_Stall` = (`cnt` != 0).
  - Edge with `cnt` != 0: decrement `cnt`, latch a bubble.
  - Edge with `cnt` == 0 (completion): perform the write or the read, latch all inputs into MEM/WB, return to IDLE.
- **Store commit:** each store is written exactly once, on its completing edge.
- **Load data:** read data reflects memory contents before any write on the same edge. Read is synchronous, into `O_ReadData`.
- **Branch:** a branch is never a memory access, so `O_PCSrc` is not gated by `O_Stall`.
- **Memory array:** not cleared by reset. It is zero-initialised at simulation start.

## Timing
- **Reset values:** all registered outputs 0, state IDLE, `cnt` 0.
- **Reset mid-WAIT:** aborts the access. No memory write occurs and `O_Stall` drops immediately.
- **Latency, non-memory instruction:** 1 cycle, inputs to MEM/WB outputs.
- **Latency, load/store with wait states:** `WAIT_CYCLES`+1 cycles. `O_Stall` is high for exactly `WAIT_CYCLES` cycles.
- **Back-to-back accesses:** the second access enters IDLE on the cycle after completion and stalls again. There is no idle gap in between.
- **Input stability:** inputs are sampled only at the completing edge. Upstream must hold them stable while `O_Stall` = 1.

## Configuration
- `MEM_WAIT_EN`
  - **Defined:** wait-state FSM as described above.
  - **Undefined:** every access completes in one cycle from IDLE. `O_Stall` is tied to 0, WAIT is unreachable and `WAIT_CYCLES` is ignored.

## Test plan
- **Reset:** assert `rst_n` = 0 during a WAIT → all outputs 0, and a following load from that address returns the old data (store not committed).
- **Store then load:** store 0xBEEF at `in_ALUResult` = 0x0010, `WAIT_CYCLES` = 2 → `O_Stall` high for 2 cycles. A later load from 0x0010 gives `O_ReadData` = 0xBEEF and `O_MemtoReg` = 1 one edge after the stall ends.
- **Wrap:** store 0x1234 at 0x0210 with `DEPTH` = 256 → a load from 0x0010 returns 0x1234.
- **Simultaneous read and write:** `in_MemRead` = `in_MemWrite` = 1 with data 0x00AA at 0x0004 → memory[2] = 0x00AA, `O_ReadData` = 0.
- **Branch:** `in_Branch` = 1, `in_Zero` = 1, target 0x0040 → `O_PCSrc` = 1 and `O_BranchTarget` = 0x0040 in the same cycle. With `in_Zero` = 0 → `O_PCSrc` = 0.
- **Pass-through without the macro:** with `MEM_WAIT_EN` undefined, an R-type result 0x7FFF to register 5 → `O_ALUResult` = 0x7FFF, `O_WriteRegister` = 5, `O_RegWrite` = 1 after one edge, and `O_Stall` never asserts.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM stage -> MEM/WB signal bundle for the 16-bit MIPS pipeline.
// master drives the EX/MEM side; slave is the MEM stage itself.
interface mem_access_stage_if;
    logic        in_MemRead;
    logic        in_MemWrite;
    logic        in_Branch;
    logic        in_Zero;
    logic [15:0] in_BranchTarget;
    logic        in_MemtoReg;
    logic        in_RegWrite;
    logic [15:0] in_ALUResult;
    logic [15:0] in_Write_Data;
    logic [2:0]  in_WriteRegister;

    logic        O_PCSrc;
    logic [15:0] O_BranchTarget;
    logic        O_Stall;
    logic        O_RegWrite;
    logic        O_MemtoReg;
    logic [15:0] O_ReadData;
    logic [15:0] O_ALUResult;
    logic [2:0]  O_WriteRegister;

    modport master (
        output in_MemRead, in_MemWrite, in_Branch, in_Zero, in_BranchTarget,
               in_MemtoReg, in_RegWrite, in_ALUResult, in_Write_Data, in_WriteRegister,
        input  O_PCSrc, O_BranchTarget, O_Stall, O_RegWrite, O_MemtoReg,
               O_ReadData, O_ALUResult, O_WriteRegister
    );

    modport slave (
        input  in_MemRead, in_MemWrite, in_Branch, in_Zero, in_BranchTarget,
               in_MemtoReg, in_RegWrite, in_ALUResult, in_Write_Data, in_WriteRegister,
        output O_PCSrc, O_BranchTarget, O_Stall, O_RegWrite, O_MemtoReg,
               O_ReadData, O_ALUResult, O_WriteRegister
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: word data memory, branch resolve and MEM/WB register, all on the falling edge.
// Optional wait-state FSM enabled by defining MEM_WAIT_EN.
module mem_access_stage #(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_stage_if.slave bus
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        regwrite_q, regwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic [15:0] read_data_q, read_data_d;
    logic [15:0] alu_result_q, alu_result_d;
    logic [2:0]  wreg_q, wreg_d;

    logic [15:0] mem [DEPTH];

    logic [AW-1:0] addr;
    logic          access;
    logic          complete;
    logic          bubble;
    logic          stall;
    logic          mem_we;
    logic [15:0]   mem_rdata;

    assign addr      = bus.in_ALUResult[AW:1];
    assign access    = bus.in_MemRead | bus.in_MemWrite;
    assign mem_rdata = mem[addr];

    // Upper address bits alias; bit 0 has no byte lanes behind it.
    logic unused_bits;
    assign unused_bits = ^{bus.in_ALUResult[15:AW+1], bus.in_ALUResult[0], CNT_INIT};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        bubble   = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef MEM_WAIT_EN
                if (access) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    complete = 1'b1;
                end
`else
                complete = 1'b1;
`endif
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        wreg_d       = wreg_q;
        if (complete) begin
            regwrite_d   = bus.in_RegWrite;
            memtoreg_d   = bus.in_MemtoReg;
            alu_result_d = bus.in_ALUResult;
            wreg_d       = bus.in_WriteRegister;
            // Read+write together behaves as a store; load data forced to 0.
            read_data_d  = (bus.in_MemRead & ~bus.in_MemWrite) ? mem_rdata : 16'h0000;
        end else if (bubble) begin
            regwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            wreg_d     = 3'd0;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            read_data_q  <= 16'h0000;
            alu_result_q <= 16'h0000;
            wreg_q       <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            wreg_q       <= wreg_d;
        end
    end

    // Write only on the completing edge so a store commits exactly once.
    assign mem_we = complete & bus.in_MemWrite & rst_n;

    always_ff @(negedge clk) begin
        if (mem_we) mem[addr] <= bus.in_Write_Data;
    end

    assign bus.O_PCSrc         = bus.in_Branch & bus.in_Zero;
    assign bus.O_BranchTarget  = bus.in_BranchTarget;
    assign bus.O_Stall         = stall & rst_n;
    assign bus.O_RegWrite      = regwrite_q;
    assign bus.O_MemtoReg      = memtoreg_q;
    assign bus.O_ReadData      = read_data_q;
    assign bus.O_ALUResult     = alu_result_q;
    assign bus.O_WriteRegister = wreg_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage; adapts expected stall count to MEM_WAIT_EN.
module tb_mem_access_stage;
    localparam int WC = 2;
`ifdef MEM_WAIT_EN
    localparam int EXP_W = WC;
`else
    localparam int EXP_W = 0;
`endif

    typedef struct packed {
        logic mr, mw, m2r, rw;
        logic [15:0] alu, wd;
        logic [2:0] wr;
    } ex_t;

    typedef struct packed {
        logic rw, m2r;
        logic [15:0] rd, alu;
        logic [2:0] wr;
    } mw_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    mw_t sb_q[$];
    logic [15:0] mdl [256];

    mem_access_stage_if bus ();
    mem_access_stage #(.DEPTH(256), .AW(8), .WAIT_CYCLES(WC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic ex_t mk(logic mr, logic mw, logic m2r, logic rw,
                               logic [15:0] alu, logic [15:0] wd, logic [2:0] wr);
        ex_t e;
        e.mr = mr; e.mw = mw; e.m2r = m2r; e.rw = rw; e.alu = alu; e.wd = wd; e.wr = wr;
        return e;
    endfunction

    // Reference: read-before-write, store-wins on read+write, word index alu[8:1].
    function automatic mw_t model(ex_t e);
        mw_t m;
        logic [7:0] a;
        a = e.alu[8:1];
        m.rw = e.rw; m.m2r = e.m2r; m.alu = e.alu; m.wr = e.wr;
        m.rd = (e.mr && !e.mw) ? mdl[a] : 16'h0000;
        if (e.mw) mdl[a] = e.wd;
        return m;
    endfunction

    task automatic drive(ex_t e);
        bus.in_MemRead = e.mr;  bus.in_MemWrite = e.mw;
        bus.in_MemtoReg = e.m2r; bus.in_RegWrite = e.rw;
        bus.in_ALUResult = e.alu; bus.in_Write_Data = e.wd;
        bus.in_WriteRegister = e.wr;
    endtask

    function automatic mw_t observe();
        mw_t o;
        o.rw = bus.O_RegWrite; o.m2r = bus.O_MemtoReg; o.rd = bus.O_ReadData;
        o.alu = bus.O_ALUResult; o.wr = bus.O_WriteRegister;
        return o;
    endfunction

    task automatic issue(input ex_t e, output mw_t obs, output int stalls, output logic bub);
        @(posedge clk);
        drive(e);
        sb_q.push_back(model(e));
        stalls = 0;
        bub = 1'b0;
        #1;
        while (bus.O_Stall && stalls < 40) begin
            stalls++;
            @(negedge clk); #1;
            bub = bub | bus.O_RegWrite | bus.O_MemtoReg | (bus.O_WriteRegister != 3'd0);
            @(posedge clk); #1;
        end
        if (stalls >= 40) stalls = -1;
        @(negedge clk); #1;
        obs = observe();
    endtask

    task automatic test_reset();
        drive(mk(0, 0, 0, 0, 16'h0, 16'h0, 3'd0));
        bus.in_Branch = 1'b0; bus.in_Zero = 1'b0; bus.in_BranchTarget = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.O_Stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", bus.O_Stall); end
        total++; if (observe() !== '0) begin bad++; $display("FAIL rst_outs got=%h want=0", observe()); end
        @(posedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        mw_t obs, exp; int st; logic bub;
        issue(mk(0, 1, 0, 0, 16'h0010, 16'hBEEF, 3'd0), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs !== exp) begin bad++; $display("FAIL st_out got=%h want=%h", obs, exp); end
        total++; if (st !== EXP_W) begin bad++; $display("FAIL st_stall got=%0d want=%0d", st, EXP_W); end
        total++; if (bub !== 1'b0) begin bad++; $display("FAIL st_bubble got=%b want=0", bub); end
        issue(mk(1, 0, 1, 1, 16'h0010, 16'h0, 3'd3), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs !== exp || obs.rd !== 16'hBEEF || obs.m2r !== 1'b1) begin
            bad++; $display("FAIL ld_out got=%h want=%h", obs, exp); end
        total++; if (st !== EXP_W) begin bad++; $display("FAIL ld_stall got=%0d want=%0d", st, EXP_W); end
    endtask

    task automatic test_wrap();
        mw_t obs, exp; int st; logic bub;
        issue(mk(0, 1, 0, 0, 16'h0210, 16'h1234, 3'd0), obs, st, bub);
        void'(sb_q.pop_front());
        issue(mk(1, 0, 1, 1, 16'h0010, 16'h0, 3'd2), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs.rd !== 16'h1234 || obs !== exp) begin
            bad++; $display("FAIL wrap got=%h want=%h", obs.rd, 16'h1234); end
    endtask

    task automatic test_rw_both();
        mw_t obs, exp; int st; logic bub;
        issue(mk(1, 1, 1, 1, 16'h0004, 16'h00AA, 3'd1), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs.rd !== 16'h0000 || obs !== exp) begin
            bad++; $display("FAIL rw_both_rd got=%h want=0000", obs.rd); end
        issue(mk(1, 0, 1, 1, 16'h0005, 16'h0, 3'd1), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs.rd !== 16'h00AA || obs !== exp) begin
            bad++; $display("FAIL rw_both_mem got=%h want=00aa", obs.rd); end
    endtask

    task automatic test_branch();
        @(posedge clk);
        drive(mk(0, 0, 0, 0, 16'h0, 16'h0, 3'd0));
        bus.in_Branch = 1'b1; bus.in_Zero = 1'b1; bus.in_BranchTarget = 16'h0040;
        #1;
        total++; if (bus.O_PCSrc !== 1'b1) begin bad++; $display("FAIL br_taken got=%b want=1", bus.O_PCSrc); end
        total++; if (bus.O_BranchTarget !== 16'h0040) begin
            bad++; $display("FAIL br_target got=%h want=0040", bus.O_BranchTarget); end
        bus.in_Zero = 1'b0;
        #1;
        total++; if (bus.O_PCSrc !== 1'b0) begin bad++; $display("FAIL br_not_taken got=%b want=0", bus.O_PCSrc); end
        @(negedge clk); #1;
        bus.in_Branch = 1'b0;
    endtask

    task automatic test_passthru();
        mw_t obs, exp; int st; logic bub;
        issue(mk(0, 0, 0, 1, 16'h7FFF, 16'h0, 3'd5), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs !== exp || obs.alu !== 16'h7FFF || obs.wr !== 3'd5 || obs.rw !== 1'b1) begin
            bad++; $display("FAIL passthru got=%h want=%h", obs, exp); end
        total++; if (st !== 0) begin bad++; $display("FAIL passthru_stall got=%0d want=0", st); end
    endtask

    task automatic test_back_to_back();
        mw_t obs, exp; int st; logic bub;
        logic [15:0] a;
        for (int k = 0; k < 10; k++) begin
            a = 16'($urandom_range(0, 7) * 2 + 16'h0080);
            if (k % 2 == 0)
                issue(mk(0, 1, 0, 0, a, 16'($urandom), 3'd0), obs, st, bub);
            else
                issue(mk(1, 0, 1, 1, a, 16'h0, 3'(k)), obs, st, bub);
            exp = sb_q.pop_front();
            total++; if (obs !== exp) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", k, obs, exp); end
            total++; if (st !== EXP_W) begin bad++; $display("FAIL b2b_stall_%0d got=%0d want=%0d", k, st, EXP_W); end
        end
    endtask

    task automatic test_reset_mid_wait();
        mw_t obs, exp; int st; logic bub;
        issue(mk(0, 1, 0, 0, 16'h0020, 16'h5555, 3'd0), obs, st, bub);
        void'(sb_q.pop_front());
        @(posedge clk);
        drive(mk(0, 1, 0, 0, 16'h0020, 16'h9999, 3'd0));
`ifdef MEM_WAIT_EN
        @(negedge clk); #1;
`else
        #1;
`endif
        rst_n = 1'b0;
        #1;
        total++; if (bus.O_Stall !== 1'b0) begin bad++; $display("FAIL rstw_stall got=%b want=0", bus.O_Stall); end
        @(negedge clk); #1;
        total++; if (observe() !== '0) begin bad++; $display("FAIL rstw_outs got=%h want=0", observe()); end
        drive(mk(0, 0, 0, 0, 16'h0, 16'h0, 3'd0));
        @(posedge clk); rst_n = 1'b1;
        issue(mk(1, 0, 1, 1, 16'h0020, 16'h0, 3'd4), obs, st, bub);
        exp = sb_q.pop_front();
        total++; if (obs.rd !== 16'h5555 || obs !== exp) begin
            bad++; $display("FAIL rstw_old_data got=%h want=5555", obs.rd); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
        test_reset();
        test_store_load();
        test_wrap();
        test_rw_both();
        test_branch();
        test_passthru();
        test_back_to_back();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
